// File: rtl/stack_mem_pkg.sv
// stack_mem_pkg: shared types, limits and helpers for the pipelined stack memory.
//   mem_req_t   : request fields (we, addr, wdata), sized to the widest legal
//                 configuration; users zero-extend their narrower fields into it.
//   MAX_LATENCY : upper bound of the LATENCY parameter.
//   fifo_depth  : response FIFO depth needed for a given read latency.
package stack_mem_pkg;

  localparam int MAX_LATENCY = 4;
  localparam int MAX_ADDR_W  = 32;
  localparam int MAX_DATA_W  = 64;

  typedef struct packed {
    logic                  we;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
  } mem_req_t;

  // One slot per response that can be in flight (LATENCY) plus one so the
  // consumer-side handshake can overlap with a new acceptance.
  function automatic int fifo_depth(input int latency);
    return latency + 1;
  endfunction

endpackage

// File: rtl/stack_mem_rsp_fifo.sv
// stack_mem_rsp_fifo: synchronous FIFO with registered storage and occupancy count.
//   i_clk, i_rst   : clock, synchronous active-high reset (pointers/count only)
//   i_push/i_push_data : write side; push while full is accepted only with a pop
//   i_pop          : read side; ignored while empty
//   o_valid/o_data : head entry; o_data is zero while empty
//   o_count        : number of stored entries
module stack_mem_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_push_data,
  input  logic                         i_pop,
  output logic                         o_valid,
  output logic [W-1:0]                 o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  // When full, the slot being popped this edge is the one the push overwrites.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset; the head is masked while empty instead.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && w_full && !i_pop));

endmodule

// File: rtl/stack_mem_pipe.sv
// stack_mem_pipe: pipelined single-port data memory with valid/ready request and
// response handshakes and response back-pressure.
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready            : request handshake (accept when both high)
//   req_we, req_addr, req_wdata    : request fields, sampled only on acceptance
//   rsp_valid/rsp_ready, rsp_rdata : response handshake and data
//   busy                           : any response-producing request in flight
// Optional feature macro STACK_MEM_WRITE_ACK_EN: writes also return the pre-write
// word as a response and are subject to the same credit limit as reads.
//
// Handshake semantics: a transfer happens on an edge where valid && ready; a
// producer holding valid keeps its fields stable until that edge, and
// rsp_valid/rsp_rdata never change while rsp_valid && !rsp_ready.
module stack_mem_pipe
  import stack_mem_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int FIFO_D = fifo_depth(LATENCY);
  localparam int OUT_W  = $clog2(FIFO_D + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];

  mem_req_t          w_req;
  logic              w_unused;
  logic              w_accept;
  logic              w_rsp_accept;
  logic              w_pop;
  logic              w_credit;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_push;
  logic [DATA_W-1:0] w_push_data;
  logic [OUT_W-1:0]  w_pipe_occ;
  logic [OUT_W-1:0]  w_fifo_cnt;
  logic [OUT_W-1:0]  w_outstanding;

  assign w_req = '{we: req_we, addr: MAX_ADDR_W'(req_addr), wdata: MAX_DATA_W'(req_wdata)};
  // Upper struct bits are zero padding for narrower configurations.
  assign w_unused = ^w_req;

  assign w_accept      = req_valid && req_ready;
  assign w_pop         = rsp_valid && rsp_ready;
  assign w_outstanding = w_pipe_occ + w_fifo_cnt;
  assign w_credit      = (w_outstanding < OUT_W'(FIFO_D));

`ifdef STACK_MEM_WRITE_ACK_EN
  assign w_rsp_accept = w_accept;
  assign req_ready    = w_credit || w_pop;
`else
  assign w_rsp_accept = w_accept && !w_req.we;
  assign req_ready    = w_credit || w_pop || req_we;
`endif

  assign busy = (w_outstanding != '0);

  // Combinational read of the current word: a write at the same edge lands
  // after this value is captured, giving read-before-write for write acks.
  assign w_rd_data = r_mem[w_req.addr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_accept && w_req.we) begin
      r_mem[w_req.addr[ADDR_W-1:0]] <= w_req.wdata[DATA_W-1:0];
    end
  end

  // The FIFO write is the final latency stage, so only LATENCY-1 explicit
  // pipeline registers sit between the array and the FIFO.
  if (LATENCY == 1) begin : g_lat1
    assign w_push      = w_rsp_accept;
    assign w_push_data = w_rd_data;
    assign w_pipe_occ  = '0;
  end else begin : g_pipe
    localparam int NS = LATENCY - 1;

    logic [NS-1:0]     r_vld;
    logic [DATA_W-1:0] r_dat [NS];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= '0;
      end else begin
        r_vld[0] <= w_rsp_accept;
        for (int k = 1; k < NS; k++) begin
          r_vld[k] <= r_vld[k-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      r_dat[0] <= w_rd_data;
      for (int k = 1; k < NS; k++) begin
        r_dat[k] <= r_dat[k-1];
      end
    end

    always_comb begin
      w_pipe_occ = '0;
      for (int k = 0; k < NS; k++) begin
        w_pipe_occ = w_pipe_occ + OUT_W'(r_vld[k]);
      end
    end

    assign w_push      = r_vld[NS-1];
    assign w_push_data = r_dat[NS-1];
  end

  stack_mem_rsp_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_D)
  ) u_rsp_fifo (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_valid     (rsp_valid),
    .o_data      (rsp_rdata),
    .o_count     (w_fifo_cnt)
  );

endmodule

// File: tb/tb_stack_mem_pipe.sv
// tb_stack_mem_pipe: directed self-checking bench for stack_mem_pipe with the
// default parameters (DATA_W=8, ADDR_W=8, LATENCY=2).
module tb_stack_mem_pipe;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       busy;

  int n_tests;
  int n_fail;

  stack_mem_pipe #(
    .DATA_W  (8),
    .ADDR_W  (8),
    .LATENCY (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .busy      (busy)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic write_word(input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0; req_we = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    n_tests++;
    if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h required 00", rsp_rdata); end
  endtask

  task automatic test_basic_latency();
    write_word(8'h10, 8'hA5);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_req_ready: got %b required 1", req_ready); end
    step();                      // read accepted at this edge
    req_valid = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b required 0", rsp_valid); end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_inflight: got %b required 1", busy); end
    step();
    n_tests++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_at_latency: got %b required 1", rsp_valid); end
    n_tests++;
    if (rsp_rdata !== 8'hA5) begin n_fail++; $display("FAIL basic_rdata: got %h required a5", rsp_rdata); end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_head: got %b required 1", busy); end
    step();
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_drained: rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    for (int i = 0; i < 8; i++) write_word(8'(i), 8'(i));
    rsp_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'(c);
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (c < 8) begin
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_req_ready c=%0d: got %b required 1", c, req_ready); end
      end
      step();
      exp_v = (c >= 1 && c <= 8);
      n_tests++;
      if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid c=%0d: got %b required %b", c, rsp_valid, exp_v); end
      if (exp_v) begin
        n_tests++;
        if (rsp_rdata !== 8'(c - 1)) begin n_fail++; $display("FAIL b2b_rdata c=%0d: got %h required %h", c, rsp_rdata, 8'(c - 1)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic exp_rdy;
    rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_we = 1'b0;
      req_addr  = (c < 3) ? 8'(3 + c) : 8'h06;
      #1;
      exp_rdy = (c < 3);
      n_tests++;
      if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_req_ready c=%0d: got %b required %b", c, req_ready, exp_rdy); end
      if (c >= 2) begin
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h03) begin
          n_fail++; $display("FAIL bp_hold c=%0d: valid=%b rdata=%h required 1 03", c, rsp_valid, rsp_rdata);
        end
      end
      step();
    end
    req_valid = 1'b0;
`ifndef STACK_MEM_WRITE_ACK_EN
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h30; req_wdata = 8'h99;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_write_accept: got %b required 1", req_ready); end
    step();
    req_valid = 1'b0; req_we = 1'b0;
`endif
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'(3 + k)) begin
        n_fail++; $display("FAIL bp_drain k=%0d: valid=%b rdata=%h required 1 %h", k, rsp_valid, rsp_rdata, 8'(3 + k));
      end
      step();
    end
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_empty: valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
`ifndef STACK_MEM_WRITE_ACK_EN
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h30;
    step();
    req_valid = 1'b0;
    step();
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h99) begin
      n_fail++; $display("FAIL bp_stalled_write_data: valid=%b rdata=%h required 1 99", rsp_valid, rsp_rdata);
    end
    step();
`endif
  endtask

  task automatic test_write_then_read();
    write_word(8'h20, 8'h11);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h55;
    step();
    req_we = 1'b0;               // read of the same address on the next cycle
    step();
    req_valid = 1'b0;
`ifdef STACK_MEM_WRITE_ACK_EN
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h11) begin
      n_fail++; $display("FAIL wr_rd_ack: valid=%b rdata=%h required 1 11", rsp_valid, rsp_rdata);
    end
`else
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_early: valid=%b required 0", rsp_valid); end
`endif
    step();
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h55) begin
      n_fail++; $display("FAIL wr_rd_data: valid=%b rdata=%h required 1 55", rsp_valid, rsp_rdata);
    end
    step();
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int seen;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    step();
    req_addr = 8'h20;
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_outputs: valid=%b busy=%b ready=%b rdata=%h required 0 0 1 00",
                         rsp_valid, busy, req_ready, rsp_rdata);
    end
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL rst_mid_no_rsp: %0d cycles with rsp_valid required 0", seen); end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    step();
    req_valid = 1'b0;
    step();
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
      n_fail++; $display("FAIL rst_mid_storage: valid=%b rdata=%h required 1 a5", rsp_valid, rsp_rdata);
    end
    step();
  endtask

`ifdef STACK_MEM_WRITE_ACK_EN
  task automatic test_write_ack();
    write_word(8'h50, 8'h77);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h50; req_wdata = 8'h33;
    step();
    req_valid = 1'b0; req_we = 1'b0;
    step();
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h77) begin
      n_fail++; $display("FAIL ack_old_data: valid=%b rdata=%h required 1 77", rsp_valid, rsp_rdata);
    end
    step();
    req_valid = 1'b1; req_addr = 8'h50;
    step();
    req_valid = 1'b0;
    step();
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h33) begin
      n_fail++; $display("FAIL ack_new_data: valid=%b rdata=%h required 1 33", rsp_valid, rsp_rdata);
    end
    step();
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic_latency();
    test_back_to_back();
    test_backpressure();
    test_write_then_read();
    test_reset_mid();
`ifdef STACK_MEM_WRITE_ACK_EN
    test_write_ack();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
